// File: rtl/plus_pkg.sv
// Shared constants for the plus_acc calculator: operation encodings, pushbutton
// indices and small mode-decode helpers.
package plus_pkg;

    typedef enum logic [1:0] {
        MODE_ADD     = 2'b00,
        MODE_SUB     = 2'b01,
        MODE_ACC_ADD = 2'b10,
        MODE_ACC_SUB = 2'b11
    } mode_e;

    localparam int KEY_LOAD_A = 0;
    localparam int KEY_LOAD_B = 1;
    localparam int KEY_EXEC   = 2;
    localparam int KEY_CLEAR  = 3;

    function automatic logic mode_is_sub(input mode_e m);
        return (m == MODE_SUB) || (m == MODE_ACC_SUB);
    endfunction

    function automatic logic mode_uses_acc(input mode_e m);
        return (m == MODE_ACC_ADD) || (m == MODE_ACC_SUB);
    endfunction

endpackage

// File: rtl/hex_7seg.sv
// Hexadecimal nibble to active-low 7-segment glyph, bit 0 = segment a.
module hex_7seg (
    input  logic [3:0] i_nibble,
    output logic [6:0] o_seg_n
);

    // Glyph lookup for 0-F.
    always_comb begin
        o_seg_n = 7'h7F;
        case (i_nibble)
            4'h0:    o_seg_n = 7'b1000000;
            4'h1:    o_seg_n = 7'b1111001;
            4'h2:    o_seg_n = 7'b0100100;
            4'h3:    o_seg_n = 7'b0110000;
            4'h4:    o_seg_n = 7'b0011001;
            4'h5:    o_seg_n = 7'b0010010;
            4'h6:    o_seg_n = 7'b0000010;
            4'h7:    o_seg_n = 7'b1111000;
            4'h8:    o_seg_n = 7'b0000000;
            4'h9:    o_seg_n = 7'b0010000;
            4'hA:    o_seg_n = 7'b0001000;
            4'hB:    o_seg_n = 7'b0000011;
            4'hC:    o_seg_n = 7'b1000110;
            4'hD:    o_seg_n = 7'b0100001;
            4'hE:    o_seg_n = 7'b0000110;
            4'hF:    o_seg_n = 7'b0001110;
            default: o_seg_n = 7'h7F;
        endcase
    end

endmodule

// File: rtl/key_edge.sv
// Two-flop synchroniser and falling-edge detector for one active-low pushbutton;
// emits a single registered strobe per press.
module key_edge
    import plus_pkg::*;
(
    input  logic i_clk,
    input  logic i_reset,
    input  logic i_key_n,
    output logic o_strobe
);

    logic       r_sync1;
    logic       r_sync2;
    logic       r_prev;
    logic       r_armed;
    logic [1:0] r_fill;
    logic       r_strobe;

    // The reset values of the sync chain are not real samples, so a press may only
    // arm after the chain has filled and actually observed the key released.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_sync1  <= 1'b1;
            r_sync2  <= 1'b1;
            r_prev   <= 1'b1;
            r_fill   <= 2'b00;
            r_armed  <= 1'b0;
            r_strobe <= 1'b0;
        end else begin
            r_sync1  <= i_key_n;
            r_sync2  <= r_sync1;
            r_prev   <= r_sync2;
            r_fill   <= {r_fill[0], 1'b1};
            r_armed  <= r_armed | (r_fill[1] & r_sync2);
            r_strobe <= r_armed & r_prev & ~r_sync2;
        end
    end

    assign o_strobe = r_strobe;

endmodule

// File: rtl/plus_acc.sv
// Pushbutton-driven adder/subtractor with accumulator: operands loaded from
// switches, flags registered on execute, result shown on 7-segment digits.
module plus_acc
    import plus_pkg::*;
#(
    parameter int WIDTH  = 16,
    parameter int DIGITS = WIDTH / 4
) (
    input  logic                CLOCK_50,
    input  logic                reset,
    input  logic [WIDTH-1:0]    SW,
    input  logic [1:0]          mode,
    input  logic [3:0]          KEY,
    output logic [WIDTH-1:0]    result,
    output logic                carry,
    output logic                overflow,
    output logic                zero,
    output logic                err,
    output logic                done,
    output logic [7*DIGITS-1:0] HEX
);

    localparam int PAD_W = (4 * DIGITS > WIDTH) ? 4 * DIGITS : WIDTH;

    logic [3:0]       w_strobe;
    mode_e            w_mode;
    logic [WIDTH-1:0] w_x;
    logic [WIDTH-1:0] w_y;
    logic [WIDTH-1:0] w_y_eff;
    logic [WIDTH:0]   w_sum;
    logic             w_sub;
    logic             w_carry;
    logic             w_overflow;
    logic             w_ops_ok;
    logic [PAD_W-1:0] w_result_pad;

    logic [WIDTH-1:0] r_a;
    logic [WIDTH-1:0] r_b;
    logic             r_a_valid;
    logic             r_b_valid;
    logic [WIDTH-1:0] r_result;
    logic             r_carry;
    logic             r_overflow;
    logic             r_zero;
    logic             r_err;
    logic             r_done;

    for (genvar g = 0; g < 4; g++) begin : g_key
        key_edge u_key_edge (
            .i_clk    (CLOCK_50),
            .i_reset  (reset),
            .i_key_n  (KEY[g]),
            .o_strobe (w_strobe[g])
        );
    end

    assign w_mode = mode_e'(mode);

    // Operand select and a single WIDTH+1 adder; subtract is X + ~Y + 1.
    always_comb begin
        w_x = r_a;
        w_y = r_b;
        case (w_mode)
            MODE_ADD, MODE_SUB: begin
                w_x = r_a;
                w_y = r_b;
            end
            MODE_ACC_ADD, MODE_ACC_SUB: begin
                w_x = r_result;
                w_y = r_a;
            end
            default: begin
                w_x = r_a;
                w_y = r_b;
            end
        endcase
        w_sub = mode_is_sub(w_mode);
        if (w_sub) begin
            w_y_eff = ~w_y;
        end else begin
            w_y_eff = w_y;
        end
        w_sum = {1'b0, w_x} + {1'b0, w_y_eff} + {{WIDTH{1'b0}}, w_sub};
        if (w_sub) begin
            w_carry = ~w_sum[WIDTH];
        end else begin
            w_carry = w_sum[WIDTH];
        end
        w_overflow = (w_x[WIDTH-1] == w_y_eff[WIDTH-1]) && (w_sum[WIDTH-1] != w_x[WIDTH-1]);
        w_ops_ok   = r_a_valid && (mode_uses_acc(w_mode) || r_b_valid);
    end

    // Operand registers and result/flag state; clear beats execute, and loads
    // land alongside an execute that still sees the old operands.
    always_ff @(posedge CLOCK_50) begin
        if (reset) begin
            r_a        <= {WIDTH{1'b0}};
            r_b        <= {WIDTH{1'b0}};
            r_a_valid  <= 1'b0;
            r_b_valid  <= 1'b0;
            r_result   <= {WIDTH{1'b0}};
            r_carry    <= 1'b0;
            r_overflow <= 1'b0;
            r_zero     <= 1'b1;
            r_err      <= 1'b0;
            r_done     <= 1'b0;
        end else begin
            r_done <= 1'b0;
            if (w_strobe[KEY_CLEAR]) begin
                r_result   <= {WIDTH{1'b0}};
                r_carry    <= 1'b0;
                r_overflow <= 1'b0;
                r_zero     <= 1'b1;
                r_err      <= 1'b0;
            end else if (w_strobe[KEY_EXEC]) begin
                if (w_ops_ok) begin
                    r_result   <= w_sum[WIDTH-1:0];
                    r_carry    <= w_carry;
                    r_overflow <= w_overflow;
                    r_zero     <= (w_sum[WIDTH-1:0] == {WIDTH{1'b0}});
                    r_err      <= 1'b0;
                    r_done     <= 1'b1;
                end else begin
                    r_err <= 1'b1;
                end
            end
            if (w_strobe[KEY_LOAD_A]) begin
                r_a       <= SW;
                r_a_valid <= 1'b1;
            end
            if (w_strobe[KEY_LOAD_B]) begin
                r_b       <= SW;
                r_b_valid <= 1'b1;
            end
        end
    end

    assign w_result_pad = PAD_W'(r_result);

    for (genvar d = 0; d < DIGITS; d++) begin : g_digit
        hex_7seg u_hex_7seg (
            .i_nibble (w_result_pad[4*d +: 4]),
            .o_seg_n  (HEX[7*d +: 7])
        );
    end

    assign result   = r_result;
    assign carry    = r_carry;
    assign overflow = r_overflow;
    assign zero     = r_zero;
    assign err      = r_err;
    assign done     = r_done;

endmodule

// File: doc/plus_acc.md
PLUS_ACC -- requirements
Module: plus_acc

Interface
REQ-001 Parameter WIDTH, default 16, operand/result width in bits; legal values are multiples of 4 from 4 to 32.
REQ-002 Parameter DIGITS, default WIDTH/4, number of 7-segment digits driven.
REQ-003 CLOCK_50  input  1  system clock (50 MHz); all state on rising edge.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 SW  input  WIDTH  operand value from DPDT switches.
REQ-006 mode  input  2  operation select: 00 A+B, 01 A-B, 10 ACC+A, 11 ACC-A.
REQ-007 KEY  input  4  raw active-low pushbuttons: [0] load A, [1] load B, [2] execute, [3] clear.
REQ-008 result  output  WIDTH  registered result (ACC register).
REQ-009 carry  output  1  carry-out on add; borrow (inverted carry) on subtract.
REQ-010 overflow  output  1  signed two's-complement overflow of last execute.
REQ-011 zero  output  1  high when result == 0.
REQ-012 err  output  1  last execute was rejected.
REQ-013 done  output  1  one-cycle pulse when result updates.
REQ-014 HEX  output  7*DIGITS  active-low segments; digit i shows result[4i+3:4i].

Function
REQ-015 Each KEY bit SHALL pass a 2-flop synchroniser, then a falling-edge detector producing a one-cycle strobe; press-to-strobe latency is 3 clocks.
REQ-016 A key held low SHALL produce exactly one strobe; no further strobe until released and pressed again.
REQ-017 Load-A strobe SHALL register SW into A and set a_valid; load-B strobe SHALL register SW into B and set b_valid.
REQ-018 Execute strobe SHALL compute per mode with a WIDTH+1-bit internal sum, registering result, carry, overflow and zero on the same edge; outputs visible 1 clock after the strobe.
REQ-019 Subtract SHALL be implemented as X + ~Y + 1; carry output SHALL be the inverted carry-out (1 = borrow).
REQ-020 overflow SHALL be set when both operand sign bits (after inversion for subtract) are equal and differ from the result sign bit.
REQ-021 Wrap-around: result SHALL be the low WIDTH bits; no saturation.
REQ-022 Modes 00/01 with b_valid=0, or any mode with a_valid=0: execute SHALL set err=1, leave result/carry/overflow unchanged, and not pulse done.
REQ-023 A successful execute SHALL clear err and pulse done for one cycle.
REQ-024 Clear strobe SHALL zero result, carry, overflow and err, set zero=1, and keep A, B, a_valid, b_valid.
REQ-025 Priority for same-cycle strobes: clear > execute > load; an execute coinciding with a load SHALL use the pre-load A/B values, and the load still takes effect.
REQ-026 mode SHALL be sampled on the execute-strobe cycle only.
REQ-027 HEX SHALL be a combinational decode of registered result (0-F glyphs).

Reset
REQ-028 On reset: A, B, result = 0; a_valid, b_valid, carry, overflow, err, done = 0; zero = 1; synchroniser and edge-detector flops = 1 (released); HEX shows all 0 digits.
REQ-029 Reset asserted while a key is held SHALL NOT generate a strobe after reset deasserts until the key is released and pressed again.
REQ-030 Reset SHALL take priority over all strobes on the same edge.

Structure
REQ-031 The mode encodings (MODE_ADD, MODE_SUB, MODE_ACC_ADD, MODE_ACC_SUB) and key-index constants SHALL live in a shared package, plus_pkg.
REQ-032 Synchroniser plus edge detector SHALL be one sub-module, key_edge, instantiated once per KEY bit; digit decode SHALL reuse existing hex_7seg, one instance per digit.

Verification (WIDTH=16)
REQ-033 Load A=0x0003, B=0x0005, mode 00, execute -> result 0x0008, carry 0, overflow 0, done one pulse, HEX0=8.
REQ-034 Same operands, mode 01 -> result 0xFFFE, carry(borrow) 1, overflow 0, zero 0.
REQ-035 A=0x7FFF, B=0x0001, mode 00 -> result 0x8000, overflow 1; A=0xFFFF, B=0x0001 -> result 0x0000, carry 1, zero 1.
REQ-036 Clear, A=0x0010, mode 10, execute three times (key released between presses) -> result 0x0030; a single key held 100 cycles gives one increment only.
REQ-037 After reset, load A only, mode 00, execute -> err 1, result 0x0000, no done; then load B and execute -> err 0.
REQ-038 Clear and execute strobed same cycle -> result 0, zero 1, no done; reset asserted mid-press -> all outputs at reset values, no strobe until re-press.
